// File: rtl/fhe_alu_pkg.sv
// Shared FHE ALU constants, AXI encodings and the frame-master state type.
package FHE_ALU_PKG;

    localparam int SLOT_NUM_IN_BUFF = 4;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DRAIN
    } axi_frame_state_t;

endpackage

// File: rtl/axi_frame_ram.sv
// Small register array: one synchronous write port, one asynchronous read port.
module axi_frame_ram #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage carries no reset; every word is written before it is read, and
    // leaving it out keeps the array mappable to plain registers without a reset tree.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fhe_axi_frame_master.sv
// Collects one frame from a stream, writes it as one INCR burst, reads the results back
// with one INCR burst and replays them on an output stream.
module fhe_axi_frame_master
    import FHE_ALU_PKG::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 10,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int WR_BEATS           = SLOT_NUM_IN_BUFF + 1,
    parameter int RD_BEATS           = SLOT_NUM_IN_BUFF,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] WR_BASE = '0,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] RD_BASE = '0
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_frame_tdata,
    input  logic                            s_frame_tvalid,
    output logic                            s_frame_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_res_tdata,
    output logic                            m_res_tvalid,
    input  logic                            m_res_tready,
    output logic                            m_res_tlast,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [2:0]                      err_o,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int MAX_BEATS = (WR_BEATS > RD_BEATS) ? WR_BEATS : RD_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    localparam int WB_AW     = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
    localparam int RB_AW     = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1;
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_BEATS - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_BEATS - 1);

    axi_frame_state_t state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, wcnt_inc, rcnt_inc;
    logic [2:0]       err_q, err_d;
    logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, w_last_q, w_last_d;
    logic b_ready_q, b_ready_d, ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
    logic res_valid_q, res_valid_d, frame_ready_q, frame_ready_d;
    logic buf_we, rbuf_we;
    logic [C_M_AXI_DATA_WIDTH-1:0] wbuf_rdata, rbuf_rdata;

    assign wcnt_inc = wcnt_q + 1'b1;
    assign rcnt_inc = rcnt_q + 1'b1;

    axi_frame_ram #(.DEPTH(WR_BEATS), .WIDTH(C_M_AXI_DATA_WIDTH)) u_buf (
        .clk(M_AXI_ACLK), .we(buf_we), .waddr(wcnt_q[WB_AW-1:0]), .wdata(s_frame_tdata),
        .raddr(wcnt_q[WB_AW-1:0]), .rdata(wbuf_rdata)
    );

    axi_frame_ram #(.DEPTH(RD_BEATS), .WIDTH(C_M_AXI_DATA_WIDTH)) u_rbuf (
        .clk(M_AXI_ACLK), .we(rbuf_we), .waddr(rcnt_q[RB_AW-1:0]), .wdata(M_AXI_RDATA),
        .raddr(rcnt_q[RB_AW-1:0]), .rdata(rbuf_rdata)
    );

    // Each VALID/READY is registered from the transition that enters its state, so it is
    // high from the first cycle of that state and drops on the edge of the final handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        err_d       = err_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        w_last_d    = w_last_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        res_valid_d = res_valid_q;
        buf_we      = 1'b0;
        rbuf_we     = 1'b0;
        case (state_q)
            ST_LOAD: if (frame_ready_q && s_frame_tvalid) begin
                buf_we = 1'b1;
                if (wcnt_q == WR_LAST) begin
                    wcnt_d     = '0;
                    aw_valid_d = 1'b1;
                    state_d    = ST_AW;
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end
            ST_AW: if (aw_valid_q && M_AXI_AWREADY) begin
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b1;
                w_last_d   = (WR_LAST == '0);
                state_d    = ST_W;
            end
            ST_W: if (w_valid_q && M_AXI_WREADY) begin
                if (wcnt_q == WR_LAST) begin
                    wcnt_d    = '0;
                    w_valid_d = 1'b0;
                    w_last_d  = 1'b0;
                    b_ready_d = 1'b1;
                    state_d   = ST_B;
                end else begin
                    wcnt_d   = wcnt_inc;
                    w_last_d = (wcnt_inc == WR_LAST);
                end
            end
            ST_B: if (b_ready_q && M_AXI_BVALID) begin
                if (M_AXI_BRESP != AXI_RESP_OKAY) err_d[0] = 1'b1;
                b_ready_d  = 1'b0;
                ar_valid_d = 1'b1;
                state_d    = ST_AR;
            end
            ST_AR: if (ar_valid_q && M_AXI_ARREADY) begin
                ar_valid_d = 1'b0;
                r_ready_d  = 1'b1;
                state_d    = ST_R;
            end
            ST_R: if (r_ready_q && M_AXI_RVALID) begin
                rbuf_we = 1'b1;
                if (M_AXI_RRESP != AXI_RESP_OKAY) err_d[1] = 1'b1;
                if (M_AXI_RLAST != (rcnt_q == RD_LAST)) err_d[2] = 1'b1;
                // The burst length is trusted over RLAST; a bad RLAST is only flagged.
                if (rcnt_q == RD_LAST) begin
                    rcnt_d      = '0;
                    r_ready_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_DRAIN;
                end else begin
                    rcnt_d = rcnt_inc;
                end
            end
            ST_DRAIN: if (res_valid_q && m_res_tready) begin
                if (rcnt_q == RD_LAST) begin
                    rcnt_d      = '0;
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    rcnt_d = rcnt_inc;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        frame_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= ST_LOAD;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            err_q         <= '0;
            aw_valid_q    <= 1'b0;
            w_valid_q     <= 1'b0;
            w_last_q      <= 1'b0;
            b_ready_q     <= 1'b0;
            ar_valid_q    <= 1'b0;
            r_ready_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            err_q         <= err_d;
            aw_valid_q    <= aw_valid_d;
            w_valid_q     <= w_valid_d;
            w_last_q      <= w_last_d;
            b_ready_q     <= b_ready_d;
            ar_valid_q    <= ar_valid_d;
            r_ready_q     <= r_ready_d;
            res_valid_q   <= res_valid_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    logic unused_ids;
    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

    assign s_frame_tready = frame_ready_q;
    assign m_res_tvalid   = res_valid_q;
    assign m_res_tdata    = rbuf_rdata;
    assign m_res_tlast    = res_valid_q && (rcnt_q == RD_LAST);
    assign done_o         = res_valid_q && m_res_tready && (rcnt_q == RD_LAST);
    assign busy_o         = (state_q != ST_LOAD);
    assign err_o          = err_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = WR_BASE;
    assign M_AXI_AWLEN   = 8'(WR_BEATS - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWVALID = aw_valid_q;

    assign M_AXI_WDATA  = wbuf_rdata;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_WLAST  = w_last_q;
    assign M_AXI_WVALID = w_valid_q;
    assign M_AXI_BREADY = b_ready_q;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = RD_BASE;
    assign M_AXI_ARLEN   = 8'(RD_BEATS - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = '0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARVALID = ar_valid_q;
    assign M_AXI_RREADY  = r_ready_q;

endmodule
